// File: rtl/debounce_pkg.sv
// Shared helpers for the debounced edge detector: counter sizing,
// parameter legality and the per-channel debounce state encoding.
package debounce_pkg;

  typedef enum logic {
    DB_IDLE     = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

  // Counter must hold values 0..DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int debounce_cycles);
    return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
  endfunction

  function automatic bit params_ok(input int n, input int sync_stages,
                                   input int debounce_cycles);
    return (n >= 1) && (n <= 32) && (sync_stages >= 2) && (debounce_cycles >= 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One channel: synchroniser, consecutive-cycle debounce counter,
// single-cycle edge pulses and sticky software-clearable flags.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_i,
  input  logic clr_i,
  output logic stable_o,
  output logic pos_edge_o,
  output logic neg_edge_o,
  output logic pos_flag_o,
  output logic neg_flag_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_q, d_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   pos_flag_q, pos_flag_d;
  logic                   neg_flag_q, neg_flag_d;
  logic                   s;
  db_state_e              state;

  assign s     = sync_q[SYNC_STAGES-1];
  // The state is implied by whether the synchronised input disagrees with d.
  assign state = (s == d_q) ? DB_IDLE : DB_COUNTING;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= {SYNC_STAGES{INIT_LEVEL}};
      d_q        <= INIT_LEVEL;
      cnt_q      <= '0;
      pos_q      <= 1'b0;
      neg_q      <= 1'b0;
      pos_flag_q <= 1'b0;
      neg_flag_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], level_i};
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      neg_q      <= neg_d;
      pos_flag_q <= pos_flag_d;
      neg_flag_q <= neg_flag_d;
    end
  end

  always_comb begin
    d_d   = d_q;
    cnt_d = '0;
    pos_d = 1'b0;
    neg_d = 1'b0;
    case (state)
      DB_COUNTING: begin
        if (cnt_q == CNT_LAST) begin
          d_d   = s;
          pos_d = s;
          neg_d = ~s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    // Set has priority over clear so a colliding event is never lost.
    pos_flag_d = pos_d | (pos_flag_q & ~clr_i);
    neg_flag_d = neg_d | (neg_flag_q & ~clr_i);
  end

  assign stable_o   = d_q;
  assign pos_edge_o = pos_q;
  assign neg_edge_o = neg_q;
  assign pos_flag_o = pos_flag_q;
  assign neg_flag_o = neg_flag_q;

endmodule

// File: rtl/debounced_edge_detector.sv
// N independent debounced edge-detector channels plus a maskable
// interrupt summarising their sticky flags.
module debounced_edge_detector
  import debounce_pkg::*;
#(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INIT_LEVEL      = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] level,
  input  logic [N-1:0] pos_en,
  input  logic [N-1:0] neg_en,
  input  logic [N-1:0] clr,
  output logic [N-1:0] stable,
  output logic [N-1:0] pos_edge,
  output logic [N-1:0] neg_edge,
  output logic [N-1:0] edge_,
  output logic [N-1:0] pos_flag,
  output logic [N-1:0] neg_flag,
  output logic         irq
);

  if (!params_ok(N, SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("debounced_edge_detector: need 1<=N<=32, SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT_LEVEL     (INIT_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .level_i   (level[gi]),
      .clr_i     (clr[gi]),
      .stable_o  (stable[gi]),
      .pos_edge_o(pos_edge[gi]),
      .neg_edge_o(neg_edge[gi]),
      .pos_flag_o(pos_flag[gi]),
      .neg_flag_o(neg_flag[gi])
    );
  end

  assign edge_ = pos_edge | neg_edge;
  assign irq   = |((pos_flag & pos_en) | (neg_flag & neg_en));

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Self-checking bench: scenario tasks with randomized stimulus compared
// against a sample-history reference model of the debounce rules.
module tb_debounced_edge_detector;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DC   = 16;
  localparam int VW   = 6 * N + 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] level, pos_en, neg_en, clr;
  logic [N-1:0] stable, pos_edge, neg_edge, edge_, pos_flag, neg_flag;
  logic         irq;

  logic [N-1:0] level1;
  logic [N-1:0] zero1 = '0;
  logic [N-1:0] stable1, pos_edge1, neg_edge1, edge1, pos_flag1, neg_flag1;
  logic         irq1;

  int errors = 0;
  int checks = 0;

  // Reference model state: history of raw samples, debounced level,
  // length of the current run of disagreeing synchronised samples.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_d, m_pos, m_neg, m_pf, m_nf;
  int           m_run[N];

  always #5 clk = ~clk;

  debounced_edge_detector #(
    .N(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .level(level), .pos_en(pos_en),
    .neg_en(neg_en), .clr(clr), .stable(stable), .pos_edge(pos_edge),
    .neg_edge(neg_edge), .edge_(edge_), .pos_flag(pos_flag),
    .neg_flag(neg_flag), .irq(irq)
  );

  debounced_edge_detector #(
    .N(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .level(level1), .pos_en(zero1),
    .neg_en(zero1), .clr(zero1), .stable(stable1), .pos_edge(pos_edge1),
    .neg_edge(neg_edge1), .edge_(edge1), .pos_flag(pos_flag1),
    .neg_flag(neg_flag1), .irq(irq1)
  );

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back('0);
    m_d = '0; m_pos = '0; m_neg = '0; m_pf = '0; m_nf = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  // The synchronised value seen before an edge is the raw sample taken SYNC edges earlier.
  task automatic model_step();
    logic [N-1:0] s_pre;
    s_pre = m_hist[SYNC-1];
    m_pos = '0;
    m_neg = '0;
    for (int ch = 0; ch < N; ch++) begin
      if (s_pre[ch] != m_d[ch]) begin
        m_run[ch] = m_run[ch] + 1;
        if (m_run[ch] == DC) begin
          m_d[ch]   = s_pre[ch];
          m_pos[ch] = s_pre[ch];
          m_neg[ch] = ~s_pre[ch];
          m_run[ch] = 0;
        end
      end else begin
        m_run[ch] = 0;
      end
      m_pf[ch] = m_pos[ch] | (m_pf[ch] & ~clr[ch]);
      m_nf[ch] = m_neg[ch] | (m_nf[ch] & ~clr[ch]);
    end
    m_hist.push_front(level);
    void'(m_hist.pop_back());
  endtask

  function automatic logic [VW-1:0] model_vec();
    return {m_d, m_pos, m_neg, m_pos | m_neg, m_pf, m_nf,
            |((m_pf & pos_en) | (m_nf & neg_en))};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {stable, pos_edge, neg_edge, edge_, pos_flag, neg_flag, irq};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; level = '0; pos_en = '0; neg_en = '0; clr = '0;
    level1 = 4'b0011;
    model_reset();
    repeat (3) tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h required 0", dut_vec());
    end
    reset_n = 1'b1;
    pos_en = '1; neg_en = '1;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (dut_vec() !== '0 || model_vec() !== '0) begin
        errors++;
        $display("FAIL reset_quiet cycle %0d: got %h required 0", c, dut_vec());
      end
    end
    pos_en = '0; neg_en = '0;
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_clean_press();
    level[0] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      checks++;
      if (pos_edge[0] !== (c == 18)) begin
        errors++;
        $display("FAIL press_pulse cycle %0d: got %b required %b", c, pos_edge[0], (c == 18));
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL press_model cycle %0d: got %h required %h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({stable[0], pos_flag[0], irq} !== 3'b110) begin
      errors++;
      $display("FAIL press_masked: got %b required 110", {stable[0], pos_flag[0], irq});
    end
    pos_en[0] = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL press_irq: got %b required 1", irq);
    end
    pos_en[0] = 1'b0;
    $display("test_clean_press done: errors=%0d", errors);
  endtask

  task automatic test_bounce();
    int highs[3] = '{5, 3, 15};
    int npulse = 0;
    for (int seg = 0; seg < 3; seg++) begin
      for (int ph = 0; ph < 2; ph++) begin
        level[1] = (ph == 0);
        repeat ((ph == 0) ? highs[seg] : 4) begin
          tick();
          if (pos_edge[1] || neg_edge[1]) npulse++;
          checks++;
          if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL bounce_model: got %h required %h", dut_vec(), model_vec());
          end
        end
      end
    end
    checks++;
    if (npulse != 0) begin
      errors++;
      $display("FAIL bounce_glitch: got %0d pulses required 0", npulse);
    end
    for (int ph = 0; ph < 2; ph++) begin
      level[1] = (ph == 0);
      for (int c = 1; c <= 22; c++) begin
        tick();
        checks++;
        if ({pos_edge[1], neg_edge[1]} !== ((c == 18) ? ((ph == 0) ? 2'b10 : 2'b01) : 2'b00)) begin
          errors++;
          $display("FAIL bounce_edge ph %0d cycle %0d: got %b", ph, c, {pos_edge[1], neg_edge[1]});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL bounce_model2: got %h required %h", dut_vec(), model_vec());
        end
      end
    end
    $display("test_bounce done: errors=%0d", errors);
  endtask

  task automatic test_clear_collision();
    clr = '1;
    tick();
    clr = '0;
    neg_en = 4'b0100;
    level[2] = 1'b1;
    repeat (22) tick();
    level[2] = 1'b0;
    repeat (17) tick();
    clr[2] = 1'b1;
    tick();
    checks++;
    if ({neg_edge[2], neg_flag[2], irq} !== 3'b111) begin
      errors++;
      $display("FAIL clr_collision: got %b required 111", {neg_edge[2], neg_flag[2], irq});
    end
    clr[2] = 1'b0;
    tick();
    checks++;
    if ({neg_edge[2], neg_flag[2], irq} !== 3'b011) begin
      errors++;
      $display("FAIL clr_hold: got %b required 011", {neg_edge[2], neg_flag[2], irq});
    end
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    checks++;
    if ({neg_flag[2], irq} !== 2'b00) begin
      errors++;
      $display("FAIL clr_alone: got %b required 00", {neg_flag[2], irq});
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL clr_model: got %h required %h", dut_vec(), model_vec());
    end
    neg_en = '0;
    $display("test_clear_collision done: errors=%0d", errors);
  endtask

  task automatic test_random();
    int hold[N];
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h required %h", c, dut_vec(), model_vec());
      end
      checks++;
      if ((pos_edge & neg_edge) !== '0) begin
        errors++;
        $display("FAIL random_both cycle %0d: got %b required 0", c, pos_edge & neg_edge);
      end
      for (int ch = 0; ch < N; ch++) begin
        hold[ch] = hold[ch] - 1;
        if (hold[ch] == 0) begin
          level[ch] = ~level[ch];
          hold[ch]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 40);
        end
      end
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) begin
        pos_en = N'($urandom);
        neg_en = N'($urandom);
      end
    end
    clr = '0;
    $display("test_random done: errors=%0d", errors);
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    level = '0;
    repeat (40) tick();
    level[3] = 1'b1;
    repeat (10) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({stable, pos_flag, neg_flag, pos_edge, neg_edge, irq} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got %h required 0", dut_vec());
    end
    level[3] = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (pos_edge != '0 || neg_edge != '0) npulse++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL reset_mid_model cycle %0d: got %h required %h", c, dut_vec(), model_vec());
      end
    end
    checks++;
    if (npulse != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d required 0", npulse);
    end
    $display("test_reset_mid done: errors=%0d", errors);
  endtask

  task automatic test_dc1_all_channels();
    level1 = 4'b0011;
    repeat (8) tick();
    level1 = 4'b1100;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++;
      if ({pos_edge1, neg_edge1, edge1} !== ((c == 3) ? 12'b1100_0011_1111 : 12'h000)) begin
        errors++;
        $display("FAIL dc1_pulses cycle %0d: got %b", c, {pos_edge1, neg_edge1, edge1});
      end
      checks++;
      if (stable1 !== ((c >= 3) ? 4'b1100 : 4'b0011)) begin
        errors++;
        $display("FAIL dc1_stable cycle %0d: got %b", c, stable1);
      end
    end
    $display("test_dc1_all_channels done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_clear_collision();
    test_random();
    test_reset_mid();
    test_dc1_all_channels();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
